// File: rtl/wb2stream_pkg.sv
// Shared constants for the byte-command link between wb2stream and the
// remote stream-to-Wishbone bridge.
package wb2stream_pkg;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    localparam logic [2:0] WR_LEN  = 3'd7;
    localparam logic [2:0] RD_LEN  = 3'd3;
    localparam logic [2:0] RSP_LEN = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RSP,
        ST_ACK
    } state_e;

    // Frames are left-justified so the top byte is always the next to send.
    function automatic logic [55:0] build_frame(
        input logic        we,
        input logic [15:0] addr,
        input logic [31:0] wdata
    );
        return we ? {OP_WRITE, addr, wdata} : {OP_READ, addr, 32'h0};
    endfunction

endpackage

// File: rtl/wb2stream.sv
// Wishbone classic slave that serializes each access into command bytes
// and collects the 4-byte read response from the return stream.
module wb2stream
    import wb2stream_pkg::*;
#(
    parameter int TIMEOUT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] wb_addr,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        err
);

    localparam logic [TIMEOUT_W-1:0] TMO_ONE = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] TMO_MAX = {TIMEOUT_W{1'b1}};

    state_e                 state_q;
    logic [55:0]            shift_q;
    logic [2:0]             cnt_q;
    logic [2:0]             rx_cnt_q;
    logic [TIMEOUT_W-1:0]   tmo_q;
    logic [TIMEOUT_W-1:0]   tmo_d;
    logic [23:0]            rx_shift_q;
    logic [31:0]            rdata_q;
    logic                   we_q;
    logic                   tx_valid_q;
    logic                   ack_q;
    logic                   err_q;
    logic                   hold_q;
    logic                   xfer;

    assign xfer  = tx_valid_q & tx_ready;
    assign tmo_d = tmo_q + TMO_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            rx_cnt_q   <= '0;
            tmo_q      <= '0;
            rx_shift_q <= '0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    hold_q <= 1'b0;
                    // hold_q blocks a re-trigger in the cycle right after ACK
                    if (wb_cyc && !hold_q) begin
                        shift_q    <= build_frame(wb_we, wb_addr, wb_wdata);
                        cnt_q      <= wb_we ? WR_LEN : RD_LEN;
                        we_q       <= wb_we;
                        err_q      <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        shift_q <= {shift_q[47:0], 8'h00};
                        cnt_q   <= cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            tx_valid_q <= 1'b0;
                            if (we_q) begin
                                ack_q   <= 1'b1;
                                state_q <= ST_ACK;
                            end else begin
                                rx_cnt_q <= '0;
                                tmo_q    <= '0;
                                state_q  <= ST_WAIT_RSP;
                            end
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    // A byte arriving on the expiry cycle wins over the timeout
                    if (rx_valid) begin
                        rx_shift_q <= {rx_shift_q[15:0], rx_data};
                        rx_cnt_q   <= rx_cnt_q + 3'd1;
                        tmo_q      <= '0;
                        if (rx_cnt_q == RSP_LEN - 3'd1) begin
                            rdata_q <= {rx_shift_q, rx_data};
                            ack_q   <= 1'b1;
                            state_q <= ST_ACK;
                        end
                    end else if (tmo_d == TMO_MAX) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'hFFFF_FFFF;
                        ack_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                ST_ACK: begin
                    ack_q   <= 1'b0;
                    hold_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // An abandoned cycle still completes its frame but gets no ack.
    assign wb_ack   = ack_q & wb_cyc;
    assign wb_rdata = rdata_q;
    assign tx_data  = shift_q[55:48];
    assign tx_valid = tx_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_wb2stream.sv
// Directed bench for wb2stream: frames, latency, backpressure, timeout,
// stray response bytes, abandoned cycles and mid-frame reset.
module tb_wb2stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic [31:0] wb_rdata;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        err;

    wb2stream #(.TIMEOUT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_addr  (wb_addr),
        .wb_wdata (wb_wdata),
        .wb_rdata (wb_rdata),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [7:0]  tx_q[$];
    int          xfer_cyc[$];
    int          ack_cnt = 0;
    int          ack_cyc = 0;
    int          rx_cyc = 0;
    logic [31:0] ack_rdata = '0;
    logic        stall_q = 1'b0;
    logic [7:0]  stall_data = '0;
    logic        bp_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(stall_data));
            end
            if (tx_valid && tx_ready) begin
                tx_q.push_back(tx_data);
                xfer_cyc.push_back(cyc);
            end
            if (wb_ack) begin
                ack_cnt++;
                ack_cyc = cyc;
                ack_rdata = wb_rdata;
            end
            if (rx_valid) rx_cyc = cyc;
            stall_q = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    task automatic clear_log();
        tx_q.delete();
        xfer_cyc.delete();
        ack_cnt = 0;
    endtask

    task automatic wait_tx(input int n);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (tx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_tx", 32'(ok), 32'd1);
    endtask

    task automatic rx_send(input logic [7:0] b, input int gap);
        @(posedge clk);
        #1;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic run_access(input logic we, input logic [15:0] addr,
                              input logic [31:0] wdata, input logic linger);
        logic got;
        @(posedge clk);
        #1;
        wb_we = we;
        wb_addr = addr;
        wb_wdata = wdata;
        wb_cyc = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wb_ack) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (linger) begin
            @(posedge clk);
            #1;
        end
        wb_cyc = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [55:0] exp,
                               input int n);
        logic [55:0] f;
        f = exp;
        check({tag, "_len"}, 32'(tx_q.size()), 32'(n));
        for (int i = 0; i < n && i < tx_q.size(); i++)
            check({tag, "_byte"}, 32'(tx_q[i]), 32'(f[55-8*i -: 8]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("rst_txv", 32'(tx_valid), 32'd0);
        check("rst_txd", 32'(tx_data), 32'd0);
        check("rst_rdata", wb_rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Write with a stray rx byte during SEND, cyc held one extra cycle
        clear_log();
        fork
            run_access(1'b1, 16'h1234, 32'hDEADBEEF, 1'b1);
            begin
                wait_tx(2);
                rx_send(8'h99, 0);
            end
        join
        @(negedge clk);
        check("wr_retrig", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("wr_retrig2", 32'(tx_valid), 32'd0);
        check_frame("wr", 56'h01_1234_DEADBEEF, 7);
        if (xfer_cyc.size() == 7) begin
            check("wr_consec", 32'(xfer_cyc[6] - xfer_cyc[0]), 32'd6);
            check("wr_ack_lat", 32'(ack_cyc), 32'(xfer_cyc[6] + 1));
        end
        check("wr_ack_cnt", 32'(ack_cnt), 32'd1);
        check("wr_rdata", wb_rdata, 32'd0);

        // Read with gapped response bytes
        clear_log();
        fork
            run_access(1'b0, 16'h00A5, 32'h0, 1'b0);
            begin
                wait_tx(3);
                rx_send(8'h11, 2);
                rx_send(8'h22, 0);
                rx_send(8'h33, 3);
                rx_send(8'h44, 1);
            end
        join
        check_frame("rd", {8'h02, 16'h00A5, 32'h0}, 3);
        check("rd_ack_lat", 32'(ack_cyc), 32'(rx_cyc + 1));
        check("rd_ack_rdata", ack_rdata, 32'h11223344);
        check("rd_err", 32'(err), 32'd0);

        // Write under random backpressure; rdata must not change
        clear_log();
        bp_on = 1'b1;
        fork
            begin
                run_access(1'b1, 16'h0042, 32'h01020304, 1'b0);
                bp_on = 1'b0;
            end
            while (bp_on) begin
                @(posedge clk);
                #1;
                tx_ready = 1'($urandom_range(0, 1));
            end
        join
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_frame("bp", 56'h01_0042_01020304, 7);
        check("bp_ack_cnt", 32'(ack_cnt), 32'd1);
        check("bp_rdata", wb_rdata, 32'h11223344);

        // Read timeout after two response bytes
        clear_log();
        fork
            run_access(1'b0, 16'h0777, 32'h0, 1'b0);
            begin
                wait_tx(3);
                rx_send(8'hAA, 0);
                rx_send(8'hBB, 1);
            end
        join
        check("to_ack_lat", 32'(ack_cyc), 32'(rx_cyc + 16));
        check("to_rdata", ack_rdata, 32'hFFFFFFFF);
        check("to_err", 32'(err), 32'd1);

        clear_log();
        run_access(1'b1, 16'h0001, 32'h00000002, 1'b0);
        check("to_err_clr", 32'(err), 32'd0);
        check("to_wr_rdata", wb_rdata, 32'hFFFFFFFF);

        // Stray rx bytes in IDLE and during SEND of a read
        clear_log();
        rx_send(8'h55, 0);
        fork
            run_access(1'b0, 16'h0100, 32'h0, 1'b0);
            begin
                wait_tx(1);
                rx_send(8'h55, 0);
                wait_tx(3);
                rx_send(8'hCA, 0);
                rx_send(8'hFE, 2);
                rx_send(8'hF0, 0);
                rx_send(8'h0D, 1);
            end
        join
        check("stray_rdata", ack_rdata, 32'hCAFEF00D);
        check("stray_ack_lat", 32'(ack_cyc), 32'(rx_cyc + 1));

        // Cycle abandoned mid-frame: frame completes, no ack
        clear_log();
        @(posedge clk);
        #1;
        wb_we = 1'b1;
        wb_addr = 16'hBEEF;
        wb_wdata = 32'h0;
        wb_cyc = 1'b1;
        wait_tx(2);
        wb_cyc = 1'b0;
        wait_tx(7);
        repeat (3) @(negedge clk);
        check_frame("drop", 56'h01_BEEF_00000000, 7);
        check("drop_ack_cnt", 32'(ack_cnt), 32'd0);

        // Reset mid-SEND
        clear_log();
        @(posedge clk);
        #1;
        wb_we = 1'b1;
        wb_addr = 16'h5678;
        wb_wdata = 32'h11111111;
        wb_cyc = 1'b1;
        wait_tx(3);
        rst_n = 1'b0;
        #1;
        check("rstm_txv", 32'(tx_valid), 32'd0);
        check("rstm_ack", 32'(wb_ack), 32'd0);
        wb_cyc = 1'b0;
        @(posedge clk);
        #1;
        check("rstm_rdata", wb_rdata, 32'd0);
        rst_n = 1'b1;
        clear_log();
        run_access(1'b1, 16'h9ABC, 32'h12345678, 1'b0);
        check_frame("post_rst", 56'h01_9ABC_12345678, 7);
        check("post_rst_ack", 32'(ack_cnt), 32'd1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
